// File: rtl/wb_write_queue.sv
// Purpose : in-order write-back queue merging memory and ALU results onto the single register-file write port.
// Latency : a result accepted into an empty queue drives write_back on the very next clock edge.
// Backpr. : mem_ready/alu_ready drop as the queue fills (memory result has priority); the pop side never stalls.
//
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   mem_valid/mem_addr/mem_data      - memory-stage result in, mem_ready out (combinational)
//   alu_valid/alu_addr/alu_data      - ALU result in, alu_ready out (combinational)
//   write_back/write_addr/write_data - registered register-file write port
//   pending                          - bit r set while a queued or issuing write targets register r
//   queue_empty                      - nothing queued and no write issuing
// Optional build macro WB_FWD_EN: adds fwd_addr in, fwd_hit/fwd_data out (combinational lookup).
module wb_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [2:0]  mem_addr,
    input  logic [15:0] mem_data,
    output logic        mem_ready,
    input  logic        alu_valid,
    input  logic [2:0]  alu_addr,
    input  logic [15:0] alu_data,
    output logic        alu_ready,
`ifdef WB_FWD_EN
    input  logic [2:0]  fwd_addr,
    output logic        fwd_hit,
    output logic [15:0] fwd_data,
`endif
    output logic        write_back,
    output logic [2:0]  write_addr,
    output logic [15:0] write_data,
    output logic [7:0]  pending,
    output logic        queue_empty
);

    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One register can have every queue slot plus the issuing write outstanding.
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PCW = $clog2(DEPTH + 2);

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_TWO  = CW'(DEPTH - 2);

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
    } entry_t;

    entry_t         fifo_q [DEPTH];
    entry_t         fifo_d [DEPTH];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PCW-1:0] pend_q [8];
    logic [PCW-1:0] pend_d [8];
    logic           write_back_q, write_back_d;
    logic [2:0]     write_addr_q, write_addr_d;
    logic [15:0]    write_data_q, write_data_d;

    logic           mem_fire;
    logic           alu_fire;
    logic           pop;
    logic [PW-1:0]  wr_ptr;

    // Readiness looks only at the count at the start of the cycle; a
    // same-cycle pop never frees a slot early.
    always_comb begin
        mem_ready = (count_q < CNT_FULL);
        alu_ready = (count_q <= CNT_TWO) || ((count_q == CNT_LAST) && !mem_valid);
    end

    assign mem_fire = mem_valid && mem_ready;
    assign alu_fire = alu_valid && alu_ready;
    assign pop      = (count_q != '0);

    // Queue and write-port next state.
    always_comb begin
        fifo_d       = fifo_q;
        head_d       = head_q;
        write_back_d = pop;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        wr_ptr       = tail_q;

        if (pop) begin
            write_addr_d = fifo_q[head_q].addr;
            write_data_d = fifo_q[head_q].data;
            head_d       = head_q + PW'(1);
        end

        // Memory result is the older instruction, so it takes the first slot.
        if (mem_fire) begin
            fifo_d[wr_ptr].addr = mem_addr;
            fifo_d[wr_ptr].data = mem_data;
            wr_ptr              = wr_ptr + PW'(1);
        end
        if (alu_fire) begin
            fifo_d[wr_ptr].addr = alu_addr;
            fifo_d[wr_ptr].data = alu_data;
            wr_ptr              = wr_ptr + PW'(1);
        end
        tail_d = wr_ptr;

        count_d = count_q + CW'(mem_fire) + CW'(alu_fire) - CW'(pop);
    end

    // Per-register outstanding-write counters. A write stops counting once it
    // has been presented on the write port for its one cycle.
    always_comb begin
        for (int r = 0; r < 8; r++) begin
            pend_d[r] = pend_q[r];
            if (mem_fire && (mem_addr == 3'(r))) begin
                pend_d[r] = pend_d[r] + PCW'(1);
            end
            if (alu_fire && (alu_addr == 3'(r))) begin
                pend_d[r] = pend_d[r] + PCW'(1);
            end
            if (write_back_q && (write_addr_q == 3'(r))) begin
                pend_d[r] = pend_d[r] - PCW'(1);
            end
        end
    end

    // Entry storage needs no reset: only slots below count are ever read.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            write_back_q <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            for (int r = 0; r < 8; r++) begin
                pend_q[r] <= '0;
            end
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            write_back_q <= write_back_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            for (int r = 0; r < 8; r++) begin
                pend_q[r] <= pend_d[r];
            end
        end
    end

    assign write_back  = write_back_q;
    assign write_addr  = write_addr_q;
    assign write_data  = write_data_q;
    assign queue_empty = (count_q == '0) && !write_back_q;

    always_comb begin
        pending = '0;
        for (int r = 0; r < 8; r++) begin
            pending[r] = (pend_q[r] != '0);
        end
    end

`ifdef WB_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Walk queued entries oldest to youngest so the last match wins; the
    // issuing output register is older than anything still queued.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = write_data_q;
        fwd_idx  = head_q;
        if (write_back_q && (write_addr_q == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = write_data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (fifo_q[fwd_idx].addr == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_q[fwd_idx].data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Purpose : self-checking bench for wb_write_queue against a queue-based reference model.
// Latency : model pops at each edge when non-empty, so writes appear one edge after acceptance.
// Backpr. : model derives readiness from the start-of-cycle queue size.
module tb_wb_write_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic [2:0]  mem_addr = '0;
    logic [15:0] mem_data = '0;
    logic        mem_ready;
    logic        alu_valid = 1'b0;
    logic [2:0]  alu_addr = '0;
    logic [15:0] alu_data = '0;
    logic        alu_ready;
    logic        write_back;
    logic [2:0]  write_addr;
    logic [15:0] write_data;
    logic [7:0]  pending;
    logic        queue_empty;
`ifdef WB_FWD_EN
    logic [2:0]  fwd_addr = '0;
    logic        fwd_hit;
    logic [15:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: program-order list of queued results plus the write port.
    ent_t        mq[$];
    logic        m_wb;
    logic [2:0]  m_waddr;
    logic [15:0] m_wdata;
    logic [15:0] dut_rf [8];
    int          n_acc;
    int          n_wr;

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .alu_valid   (alu_valid),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
`ifdef WB_FWD_EN
        .fwd_addr    (fwd_addr),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
`endif
        .write_back  (write_back),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .pending     (pending),
        .queue_empty (queue_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic model_mem_rdy();
        return mq.size() < DEPTH;
    endfunction

    function automatic logic model_alu_rdy(input logic mv);
        int c;
        c = mq.size();
        return (c <= DEPTH - 2) || ((c == DEPTH - 1) && !mv);
    endfunction

    function automatic logic [7:0] model_pending();
        logic [7:0] p;
        p = '0;
        foreach (mq[i]) p[mq[i].addr] = 1'b1;
        if (m_wb) p[m_waddr] = 1'b1;
        return p;
    endfunction

    function automatic logic model_empty();
        return (mq.size() == 0) && !m_wb;
    endfunction

    function automatic void model_fwd(input logic [2:0] a, output logic hit, output logic [15:0] d);
        hit = 1'b0;
        d   = m_wdata;
        if (m_wb && m_waddr == a) hit = 1'b1;
        foreach (mq[i]) begin
            if (mq[i].addr == a) begin
                hit = 1'b1;
                d   = mq[i].data;
            end
        end
    endfunction

    task automatic set_in(input logic mv, input logic [2:0] ma, input logic [15:0] md,
                          input logic av, input logic [2:0] aa, input logic [15:0] ad);
        mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad;
    endtask

    // Advance one clock; the model consumes the inputs held across the edge.
    task automatic tick();
        logic mf, af;
        ent_t e;
        mf = mem_valid && model_mem_rdy();
        af = alu_valid && model_alu_rdy(mem_valid);
        @(posedge clk);
        if (mq.size() > 0) begin
            e = mq.pop_front();
            m_wb = 1'b1; m_waddr = e.addr; m_wdata = e.data;
        end else begin
            m_wb = 1'b0;
        end
        if (mf) begin e.addr = mem_addr; e.data = mem_data; mq.push_back(e); n_acc++; end
        if (af) begin e.addr = alu_addr; e.data = alu_data; mq.push_back(e); n_acc++; end
        #1;
        if (write_back === 1'b1) begin
            dut_rf[write_addr] = write_data;
            n_wr++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        m_wb = 1'b0; m_waddr = '0; m_wdata = '0;
        n_acc = 0; n_wr = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (write_back !== 1'b0) begin errors++; $display("FAIL reset_wb: got %b exp 0", write_back); end
        checks++; if (write_addr !== 3'd0) begin errors++; $display("FAIL reset_waddr: got %0d exp 0", write_addr); end
        checks++; if (write_data !== 16'h0) begin errors++; $display("FAIL reset_wdata: got %h exp 0000", write_data); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h exp 00", pending); end
        checks++; if (queue_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b exp 1", queue_empty); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready: got %b exp 1", mem_ready); end
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready: got %b exp 1", alu_ready); end
    endtask

    task automatic test_single();
        set_in(0, 0, 0, 1, 3'd3, 16'h1234);
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready: got %b exp 1", alu_ready); end
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (write_back !== 1'b0) begin errors++; $display("FAIL single_wb_early: got %b exp 0", write_back); end
        checks++; if (pending !== 8'h08) begin errors++; $display("FAIL single_pend1: got %h exp 08", pending); end
        tick();
        checks++; if (write_back !== 1'b1) begin errors++; $display("FAIL single_wb: got %b exp 1", write_back); end
        checks++; if (write_addr !== 3'd3) begin errors++; $display("FAIL single_waddr: got %0d exp 3", write_addr); end
        checks++; if (write_data !== 16'h1234) begin errors++; $display("FAIL single_wdata: got %h exp 1234", write_data); end
        checks++; if (pending !== 8'h08) begin errors++; $display("FAIL single_pend2: got %h exp 08", pending); end
        tick();
        checks++; if (write_back !== 1'b0) begin errors++; $display("FAIL single_wb_end: got %b exp 0", write_back); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL single_pend3: got %h exp 00", pending); end
        checks++; if (queue_empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b exp 1", queue_empty); end
    endtask

    task automatic test_same_reg();
        set_in(1, 3'd1, 16'hAAAA, 1, 3'd1, 16'h5555);
        #1;
        checks++; if ({mem_ready, alu_ready} !== 2'b11) begin errors++; $display("FAIL same_ready: got %b exp 11", {mem_ready, alu_ready}); end
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        checks++; if (pending !== 8'h02) begin errors++; $display("FAIL same_pend0: got %h exp 02", pending); end
        tick();
        checks++; if ({write_back, write_addr, write_data} !== {1'b1, 3'd1, 16'hAAAA}) begin errors++;
            $display("FAIL same_first: got %b/%0d/%h exp 1/1/aaaa", write_back, write_addr, write_data); end
        checks++; if (pending !== 8'h02) begin errors++; $display("FAIL same_pend1: got %h exp 02", pending); end
        tick();
        checks++; if ({write_back, write_addr, write_data} !== {1'b1, 3'd1, 16'h5555}) begin errors++;
            $display("FAIL same_second: got %b/%0d/%h exp 1/1/5555", write_back, write_addr, write_data); end
        checks++; if (pending !== 8'h02) begin errors++; $display("FAIL same_pend2: got %h exp 02", pending); end
        tick();
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL same_pend3: got %h exp 00", pending); end
        checks++; if (dut_rf[1] !== 16'h5555) begin errors++; $display("FAIL same_rf: got %h exp 5555", dut_rf[1]); end
    endtask

    task automatic test_back_to_back();
        n_acc = 0; n_wr = 0;
        for (int i = 0; i < 10; i++) begin
            set_in(1, 3'($urandom_range(0, 7)), 16'($urandom), 1, 3'($urandom_range(0, 7)), 16'($urandom));
            #1;
            checks++; if (mem_ready !== model_mem_rdy()) begin errors++; $display("FAIL b2b_mem_ready[%0d]: got %b exp %b", i, mem_ready, model_mem_rdy()); end
            checks++; if (alu_ready !== model_alu_rdy(1'b1)) begin errors++; $display("FAIL b2b_alu_ready[%0d]: got %b exp %b", i, alu_ready, model_alu_rdy(1'b1)); end
            if (i >= 2) begin
                checks++; if ({mem_ready, alu_ready} !== 2'b10) begin errors++; $display("FAIL b2b_throttle[%0d]: got %b exp 10", i, {mem_ready, alu_ready}); end
            end
            tick();
            checks++; if ({write_back, write_addr, write_data} !== {m_wb, m_waddr, m_wdata}) begin errors++;
                $display("FAIL b2b_write[%0d]: got %b/%0d/%h exp %b/%0d/%h", i, write_back, write_addr, write_data, m_wb, m_waddr, m_wdata); end
        end
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if ({write_back, write_addr, write_data} !== {m_wb, m_waddr, m_wdata}) begin errors++;
                $display("FAIL b2b_drain[%0d]: got %b/%0d/%h exp %b/%0d/%h", i, write_back, write_addr, write_data, m_wb, m_waddr, m_wdata); end
        end
        checks++; if (n_wr !== n_acc) begin errors++; $display("FAIL b2b_count: got %0d writes exp %0d", n_wr, n_acc); end
        checks++; if (queue_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b exp 1", queue_empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            set_in(1, 3'($urandom_range(0, 7)), 16'($urandom), 1, 3'($urandom_range(0, 7)), 16'($urandom));
            tick();
        end
        do_reset();
        checks++; if (write_back !== 1'b0) begin errors++; $display("FAIL rstmid_wb: got %b exp 0", write_back); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL rstmid_pending: got %h exp 00", pending); end
        checks++; if (queue_empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b exp 1", queue_empty); end
        checks++; if ({mem_ready, alu_ready} !== 2'b11) begin errors++; $display("FAIL rstmid_ready: got %b exp 11", {mem_ready, alu_ready}); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (write_back !== 1'b0) begin errors++; $display("FAIL rstmid_stale[%0d]: got %b exp 0", i, write_back); end
        end
    endtask

    task automatic test_random();
        logic mv, av, eh;
        logic [15:0] ed;
        for (int i = 0; i < 400; i++) begin
            mv = ($urandom_range(0, 99) < 60);
            av = ($urandom_range(0, 99) < 60);
            set_in(mv, 3'($urandom_range(0, 7)), 16'($urandom), av, 3'($urandom_range(0, 7)), 16'($urandom));
`ifdef WB_FWD_EN
            fwd_addr = 3'($urandom_range(0, 7));
`endif
            #1;
            checks++; if (mem_ready !== model_mem_rdy()) begin errors++; $display("FAIL rnd_mem_ready[%0d]: got %b exp %b", i, mem_ready, model_mem_rdy()); end
            checks++; if (alu_ready !== model_alu_rdy(mv)) begin errors++; $display("FAIL rnd_alu_ready[%0d]: got %b exp %b", i, alu_ready, model_alu_rdy(mv)); end
`ifdef WB_FWD_EN
            model_fwd(fwd_addr, eh, ed);
            checks++; if (fwd_hit !== eh) begin errors++; $display("FAIL rnd_fwd_hit[%0d]: got %b exp %b", i, fwd_hit, eh); end
            if (eh) begin
                checks++; if (fwd_data !== ed) begin errors++; $display("FAIL rnd_fwd_data[%0d]: got %h exp %h", i, fwd_data, ed); end
            end
`else
            eh = 1'b0; ed = '0;
`endif
            tick();
            checks++; if ({write_back, write_addr, write_data} !== {m_wb, m_waddr, m_wdata}) begin errors++;
                $display("FAIL rnd_write[%0d]: got %b/%0d/%h exp %b/%0d/%h", i, write_back, write_addr, write_data, m_wb, m_waddr, m_wdata); end
            checks++; if (pending !== model_pending()) begin errors++; $display("FAIL rnd_pending[%0d]: got %h exp %h", i, pending, model_pending()); end
            checks++; if (queue_empty !== model_empty()) begin errors++; $display("FAIL rnd_empty[%0d]: got %b exp %b", i, queue_empty, model_empty()); end
        end
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH + 2; i++) tick();
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL rnd_final_pending: got %h exp 00", pending); end
        checks++; if (queue_empty !== 1'b1) begin errors++; $display("FAIL rnd_final_empty: got %b exp 1", queue_empty); end
    endtask

`ifdef WB_FWD_EN
    task automatic test_fwd();
        do_reset();
        set_in(1, 3'd5, 16'h0011, 0, 0, 0);
        tick();
        set_in(1, 3'd5, 16'h0022, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        fwd_addr = 3'd5;
        #1;
        checks++; if (fwd_hit !== 1'b1) begin errors++; $display("FAIL fwd_hit5: got %b exp 1", fwd_hit); end
        checks++; if (fwd_data !== 16'h0022) begin errors++; $display("FAIL fwd_data5: got %h exp 0022", fwd_data); end
        fwd_addr = 3'd6;
        #1;
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_hit6: got %b exp 0", fwd_hit); end
        for (int i = 0; i < 3; i++) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_same_reg();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef WB_FWD_EN
        test_fwd();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
